burst_mem_responder: RTL
========================

# burst_mem_responder

Synthesizable responder for the 64-bit burst memory interface that the cache-line adapter drives. It accepts 4-beat line reads and writes and stores lines in an internal array. Read data comes back as 4 consecutive beats after a fixed latency, with a small in-order read queue. It sits on the bmem side of the adapter and replaces the external memory model in simulation and small FPGA builds.

## Interface
- ADDR_BITS, 8, line-index width; the array holds 2^ADDR_BITS lines of 256 bits.
- READ_LATENCY, 4, cycles from read accept to first rdata beat; legal range 1..15.
- QUEUE_DEPTH, 4, number of outstanding reads; legal range 1..8.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- bmem_addr  in  32  request byte address; bits [4:0] ignored; index = [5+ADDR_BITS-1:5]; higher bits ignored (aliasing).
- bmem_read  in  1  read request; counts only when bmem_ready=1.
- bmem_write  in  1  write beat valid.
- bmem_wdata  in  64  write beat data.
- bmem_ready  out  1  responder can accept a new read or the first write beat.
- bmem_raddr  out  32  address of the read currently returning, exactly as presented at accept.
- bmem_rdata  out  64  read beat data.
- bmem_rvalid  out  1  read beat valid.

## Operation
- Reset: all outputs 0, array cleared to zero, queue emptied, write FSM to W_IDLE. bmem_ready=1 from the first cycle after rst falls.
- bmem_ready = (write FSM in W_IDLE) and (queue count < QUEUE_DEPTH). It depends on state only, never on inputs.
- Write FSM states: W_IDLE, W_B1, W_B2, W_B3.
  - W_IDLE with bmem_ready and bmem_write: latch the line index and beat 0 (wdata -> bits [63:0]), go to W_B1.
  - W_B1, W_B2, W_B3: if bmem_write=1, capture the beat into bits [127:64], [191:128], [255:192] respectively. The address on these beats is ignored.
  - On W_B3 with bmem_write=1, commit the full line to the array at the edge and return to W_IDLE.
  - In any W_Bx with bmem_write=0, abort: nothing is committed, return to W_IDLE.
- Read accept: in the cycle bmem_ready and bmem_read and not bmem_write, read the array combinationally and push an entry {addr, 256-bit line, countdown=READ_LATENCY-1}. The entry is a snapshot, so later writes do not alter it.
- If bmem_read and bmem_write are both high while ready: the write wins and the read is dropped.
- Countdown: every queued entry with a nonzero countdown decrements each cycle.
- Response: the head entry becomes eligible when its countdown is 0. It then emits beats 0..3 on 4 consecutive cycles: rvalid=1, raddr=entry addr, rdata=line[64k+63:64k].
  - The entry pops at the edge ending beat 3.
  - The next eligible entry starts on the following cycle, so beats run back-to-back with no gap.
- Pop and push in the same cycle are legal. bmem_ready for that cycle uses the pre-pop count.
- Reads and writes are independent. A write may begin while responses are streaming.

## Timing
- A read accepted at edge T with an empty queue gives rvalid beats at cycles T+READ_LATENCY .. T+READ_LATENCY+3.
- Queued read i starts at the later of (its accept + READ_LATENCY) and (end of read i-1 + 1).
- A write first beat at T commits at the edge of T+3. A read accepted at T+4 sees the new data.
- bmem_ready is 0 during W_B1..W_B3, so a read cannot be accepted then.
- When rvalid=0, rdata and raddr are held at 0.
- Reset mid-operation: the next cycle has rvalid=0, the queue is flushed, any in-flight write is discarded, and the array is zeroed.

## Test plan
- Write 0x40 with beats 0x11..,0x22..,0x33..,0x44.. then read 0x40 at T -> rvalid at T+4..T+7, raddr=0x40, rdata 0x11..,0x22..,0x33..,0x44..
- 5 reads on consecutive cycles (DEPTH=4) -> first 4 accepted, ready=0 on the 5th, beats 16 contiguous; ready returns to 1 the cycle after the first pop.
- Read 0x80 (old=0), then write 0x80 with 0xAA.. before response -> read returns zeros; second read returns 0xAA..
- Write burst with bmem_write=0 at beat 2 -> FSM back to W_IDLE, line unchanged, ready=1 next cycle.
- Read and write asserted together at ready -> write accepted, no rvalid ever for that read.
- Assert rst during beat 1 of a response -> rvalid=0 next cycle; a subsequent read of that line returns all zeros.

Source files
------------

// File: rtl/burst_mem_responder.sv
// Burst memory responder: 4-beat 64-bit line writes into an internal array and
// in-order 4-beat read responses after a fixed latency, through a small read queue.
module burst_mem_responder #(
    parameter int unsigned ADDR_BITS    = 8,
    parameter int unsigned READ_LATENCY = 4,
    parameter int unsigned QUEUE_DEPTH  = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] bmem_addr_i,
    input  logic        bmem_read_i,
    input  logic        bmem_write_i,
    input  logic [63:0] bmem_wdata_i,
    output logic        bmem_ready_o,
    output logic [31:0] bmem_raddr_o,
    output logic [63:0] bmem_rdata_o,
    output logic        bmem_rvalid_o
);
    localparam int unsigned Lines = 2 ** ADDR_BITS;
    localparam int unsigned PtrW  = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int unsigned CntW  = $clog2(QUEUE_DEPTH + 1);
    localparam logic [PtrW-1:0] LastPtr  = PtrW'(QUEUE_DEPTH - 1);
    localparam logic [CntW-1:0] DepthCnt = CntW'(QUEUE_DEPTH);
    localparam logic [3:0]      StartCd  = 4'(READ_LATENCY - 1);

    typedef enum logic [1:0] {WIdle, WB1, WB2, WB3} wr_state_e;

    wr_state_e            wr_state_q, wr_state_d;
    logic [ADDR_BITS-1:0] wr_index_q, wr_index_d;
    logic [191:0]         wr_line_q, wr_line_d;
    logic                 mem_we;
    logic [255:0]         mem_q [Lines];

    logic [31:0]     q_addr_q [QUEUE_DEPTH];
    logic [31:0]     q_addr_d [QUEUE_DEPTH];
    logic [255:0]    q_line_q [QUEUE_DEPTH];
    logic [255:0]    q_line_d [QUEUE_DEPTH];
    logic [3:0]      q_cd_q   [QUEUE_DEPTH];
    logic [3:0]      q_cd_d   [QUEUE_DEPTH];
    logic [PtrW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CntW-1:0] count_q, count_d;
    logic [1:0]      beat_q, beat_d;

    logic [ADDR_BITS-1:0] req_index;
    logic                 wr_start, rd_accept, head_live, pop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == LastPtr) ? '0 : p + 1'b1;
    endfunction

    assign req_index    = bmem_addr_i[5 +: ADDR_BITS];
    assign bmem_ready_o = (wr_state_q == WIdle) && (count_q < DepthCnt);
    // A simultaneous write takes priority; the read is dropped.
    assign wr_start     = bmem_ready_o && bmem_write_i;
    assign rd_accept    = bmem_ready_o && bmem_read_i && !bmem_write_i;
    assign head_live    = (count_q != '0) && (q_cd_q[head_q] == 4'd0);
    assign pop          = head_live && (beat_q == 2'd3);

    always_comb begin
        wr_state_d = wr_state_q;
        wr_index_d = wr_index_q;
        wr_line_d  = wr_line_q;
        mem_we     = 1'b0;
        unique case (wr_state_q)
            WIdle: begin
                if (wr_start) begin
                    wr_index_d       = req_index;
                    wr_line_d[63:0]  = bmem_wdata_i;
                    wr_state_d       = WB1;
                end
            end
            WB1: begin
                wr_line_d[127:64] = bmem_wdata_i;
                wr_state_d        = bmem_write_i ? WB2 : WIdle;
            end
            WB2: begin
                wr_line_d[191:128] = bmem_wdata_i;
                wr_state_d         = bmem_write_i ? WB3 : WIdle;
            end
            WB3: begin
                mem_we     = bmem_write_i;
                wr_state_d = WIdle;
            end
            default: wr_state_d = WIdle;
        endcase
    end

    always_comb begin
        q_addr_d = q_addr_q;
        q_line_d = q_line_q;
        head_d   = head_q;
        tail_d   = tail_q;
        beat_d   = beat_q;
        count_d  = count_q;
        // Free-running countdowns; stale slots are harmless since a push reloads them.
        for (int unsigned i = 0; i < QUEUE_DEPTH; i++) begin
            q_cd_d[i] = (q_cd_q[i] != 4'd0) ? q_cd_q[i] - 4'd1 : 4'd0;
        end
        if (head_live) beat_d = beat_q + 2'd1;
        if (pop) head_d = ptr_inc(head_q);
        if (rd_accept) begin
            q_addr_d[tail_q] = bmem_addr_i;
            q_line_d[tail_q] = mem_q[req_index];
            q_cd_d[tail_q]   = StartCd;
            tail_d           = ptr_inc(tail_q);
        end
        case ({rd_accept, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        bmem_rvalid_o = head_live;
        bmem_raddr_o  = '0;
        bmem_rdata_o  = '0;
        if (head_live) begin
            bmem_raddr_o = q_addr_q[head_q];
            bmem_rdata_o = q_line_q[head_q][{beat_q, 6'd0} +: 64];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_state_q <= WIdle;
            wr_index_q <= '0;
            wr_line_q  <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            beat_q     <= '0;
            for (int unsigned i = 0; i < QUEUE_DEPTH; i++) begin
                q_addr_q[i] <= '0;
                q_line_q[i] <= '0;
                q_cd_q[i]   <= '0;
            end
            for (int unsigned i = 0; i < Lines; i++) mem_q[i] <= '0;
        end else begin
            wr_state_q <= wr_state_d;
            wr_index_q <= wr_index_d;
            wr_line_q  <= wr_line_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            beat_q     <= beat_d;
            q_addr_q   <= q_addr_d;
            q_line_q   <= q_line_d;
            q_cd_q     <= q_cd_d;
            if (mem_we) mem_q[wr_index_q] <= {bmem_wdata_i, wr_line_q};
        end
    end
endmodule
